aes_cipher_param: RTL and testbench

//  Iterative AES encryption core, FIPS-197, for AES-128/192/256 selected by NK. Computes one round per clock.

---
 rtl/aes_cipher_param.sv | 185 ++++++++++++++++++
 tb/tb_aes_cipher_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_param.sv
// Iterative AES-128/192/256 encryptor: one round per clock, on-the-fly key expansion
// using an NK-word sliding window, and valid/ready handshakes on both sides.
module aes_cipher_param #(
  parameter int NK = 4,
  parameter int NB = 128
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NB-1:0]   plain_text,
  input  logic [32*NK-1:0] key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NB-1:0]   cipher_text,
  output logic            busy
);
  localparam int NR = NK + 6;
  localparam logic [3:0] NK4 = 4'(NK);
  localparam logic [3:0] NR4 = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8) || NB != 128) begin : g_bad_param
    $fatal(1, "aes_cipher_param: NK must be 4, 6 or 8 and NB must be 128");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // State bytes are column-major: byte 4*c+r sits at [127-8*(4*c+r) -: 8].
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] sr, mc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    mc = sr;
    if (!last)
      for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    return mc ^ rk;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] d);
    case (d)
      4'd1:  return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t fsm, fsm_next;

  logic [127:0]    state;
  logic [32*NK-1:0] win, win_next;
  logic [3:0]      round, i_mod, i_div, mod_adv, div_adv, mod_sum;
  logic [31:0]     nw [4];
  logic [127:0]    rk;
  logic            accept;

  // i_mod/i_div track (j+NK)%NK and (j+NK)/NK for the first word generated this cycle.
  always_comb begin
    logic [31:0] prev, t;
    logic [3:0] m, d;
    nw = '{default: '0};
    prev = win[31:0];
    for (int k = 0; k < 4; k++) begin
      m = i_mod + 4'(k);
      d = i_div;
      if (m >= NK4) begin
        m = m - NK4;
        d = d + 4'd1;
      end
      t = prev;
      if (m == 4'd0) t = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(d), 24'h0};
      else if (NK == 8 && m == 4'd4) t = sub_word(prev);
      nw[k] = win[32*NK-1-32*k -: 32] ^ t;
      prev = nw[k];
    end
    mod_sum = i_mod + 4'd4;
    mod_adv = mod_sum;
    div_adv = i_div;
    if (mod_sum >= NK4) begin
      mod_adv = mod_sum - NK4;
      div_adv = i_div + 4'd1;
    end
  end

  if (NK == 4) begin : g_win4
    assign win_next = {nw[0], nw[1], nw[2], nw[3]};
  end else begin : g_winn
    assign win_next = {win[32*NK-129:0], nw[0], nw[1], nw[2], nw[3]};
  end

  // The round key is w[4r..4r+3], i.e. the leading four words of the advanced window.
  assign rk = win_next[32*NK-1 -: 128];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (round == NR4) fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) fsm_next = in_valid ? RUN : IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign accept      = in_valid & in_ready;
  assign cipher_text = out_valid ? state : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= '0;
      win   <= '0;
      round <= '0;
      i_mod <= '0;
      i_div <= '0;
    end else if (accept) begin
      state <= plain_text ^ key[32*NK-1 -: 128];
      win   <= key;
      round <= 4'd1;
      i_mod <= 4'd0;
      i_div <= 4'd1;
    end else if (busy) begin
      state <= round_fn(state, rk, round == NR4);
      win   <= win_next;
      if (round != NR4) round <= round + 4'd1;
      i_mod <= mod_adv;
      i_div <= div_adv;
    end
  end
endmodule

// File: tb/tb_aes_cipher_param.sv
// Bench for aes_cipher_param: NK=4/6/8 instances, known-answer vectors, and a
// scoreboard that queues the expected ciphertext on accept and checks it on handoff.
module tb_aes_cipher_param;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   iv = '0;
  logic [2:0]   ir, ov, bz;
  logic [127:0] pt = '0;
  logic [255:0] key = '0;
  logic [127:0] ct [3];
  logic [127:0] cur_exp = '0;
  logic [127:0] sb_q [$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_param #(.NK(4)) dut4 (.clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]),
    .plain_text(pt), .key(key[255:128]), .out_valid(ov[0]), .out_ready(out_ready),
    .cipher_text(ct[0]), .busy(bz[0]));
  aes_cipher_param #(.NK(6)) dut6 (.clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]),
    .plain_text(pt), .key(key[255:64]), .out_valid(ov[1]), .out_ready(out_ready),
    .cipher_text(ct[1]), .busy(bz[1]));
  aes_cipher_param #(.NK(8)) dut8 (.clk(clk), .rstn(rstn), .in_valid(iv[2]), .in_ready(ir[2]),
    .plain_text(pt), .key(key), .out_valid(ov[2]), .out_ready(out_ready),
    .cipher_text(ct[2]), .busy(bz[2]));

  // Scoreboard: inputs change #1 after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (!rstn) sb_q.delete();
    else begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected dut%0d got %h expected no output", d, ct[d]);
          end else begin
            logic [127:0] e;
            e = sb_q.pop_front();
            if (ct[d] !== e) begin
              miscompares++;
              $display("FAIL sb_ct dut%0d got %h expected %h", d, ct[d], e);
            end
          end
        end
      end
      for (int d = 0; d < 3; d++)
        if (iv[d] && ir[d]) sb_q.push_back(cur_exp);
    end
  end

  task automatic send(input int d, input logic [127:0] p, input logic [255:0] k,
                      input logic [127:0] e);
    pt = p; key = k; cur_exp = e; iv[d] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ir[d]) break;
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  // Called #1 after the accept edge; n = edges until out_valid, -1 if none.
  task automatic wait_out(input int d, output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov[d]) begin n = c; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (ir !== 3'b111) begin miscompares++; $display("FAIL rst_in_ready got %b expected 111", ir); end
    vectors++; if (ov !== 3'b000) begin miscompares++; $display("FAIL rst_out_valid got %b expected 000", ov); end
    vectors++; if (bz !== 3'b000) begin miscompares++; $display("FAIL rst_busy got %b expected 000", bz); end
    vectors++; if ((ct[0] | ct[1] | ct[2]) !== 128'h0) begin
      miscompares++; $display("FAIL rst_ct got %h expected 0", ct[0] | ct[1] | ct[2]);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips;
    int n;
    out_ready = 1'b1;
    send(0, 128'h3243f6a8885a308d313198a2e0370734, {KEY_A, 128'h0},
         128'h3925841d02dc09fbdc118597196a0b32);
    wait_out(0, n);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL fips_latency got %0d expected 10", n); end
    vectors++; if (ct[0] !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      miscompares++; $display("FAIL fips_ct got %h expected 3925841d02dc09fbdc118597196a0b32", ct[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_key_sizes;
    logic [255:0] keys [3];
    logic [127:0] exps [3];
    int lat [3];
    int n;
    keys[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    keys[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    keys[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    exps[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exps[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exps[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    lat[0] = 10; lat[1] = 12; lat[2] = 14;
    out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      send(d, PT_C, keys[d], exps[d]);
      wait_out(d, n);
      vectors++; if (n !== lat[d]) begin miscompares++; $display("FAIL ks_latency dut%0d got %0d expected %0d", d, n, lat[d]); end
      vectors++; if (ct[d] !== exps[d]) begin miscompares++; $display("FAIL ks_ct dut%0d got %h expected %h", d, ct[d], exps[d]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [127:0] e;
    e = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    out_ready = 1'b0;
    send(0, 128'h6bc1bee22e409f96e93d7e117393172a, {KEY_A, 128'h0}, e);
    wait_out(0, n);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL bp_latency got %0d expected 10", n); end
    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1;
      pt = pt ^ {4{32'hdeadbeef}};
      cur_exp = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
      @(posedge clk); #1;
      vectors++; if (ct[0] !== e || ov[0] !== 1'b1) begin
        miscompares++; $display("FAIL bp_hold cycle %0d got ct=%h valid=%b expected ct=%h valid=1", k, ct[0], ov[0], e);
      end
      vectors++; if (ir[0] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b expected 0", k, ir[0]); end
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      miscompares++; $display("FAIL bp_release got valid=%b ready=%b busy=%b expected 0 1 0", ov[0], ir[0], bz[0]);
    end
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL bp_queue got %0d pending expected 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pts [3];
    logic [127:0] exps [3];
    int out_cyc [3];
    int idx, nout;
    logic acc;
    pts[0] = 128'h3243f6a8885a308d313198a2e0370734; exps[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    pts[1] = 128'h6bc1bee22e409f96e93d7e117393172a; exps[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    pts[2] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; exps[2] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    out_cyc[0] = 0; out_cyc[1] = 0; out_cyc[2] = 0;
    idx = 0; nout = 0;
    out_ready = 1'b1;
    pt = pts[0]; key = {KEY_A, 128'h0}; cur_exp = exps[0]; iv[0] = 1'b1;
    for (int c = 0; c < 60 && nout < 3; c++) begin
      @(negedge clk);
      if (ov[0]) begin out_cyc[nout] = cyc; nout++; end
      acc = iv[0] && ir[0];
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin pt = pts[idx]; cur_exp = exps[idx]; end
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    vectors++; if (nout !== 3) begin miscompares++; $display("FAIL b2b_count got %0d expected 3", nout); end
    // Each block spends NR cycles in RUN plus the DONE cycle where the next one is taken.
    vectors++; if (out_cyc[1] - out_cyc[0] !== 11) begin miscompares++; $display("FAIL b2b_gap01 got %0d expected 11", out_cyc[1] - out_cyc[0]); end
    vectors++; if (out_cyc[2] - out_cyc[1] !== 11) begin miscompares++; $display("FAIL b2b_gap12 got %0d expected 11", out_cyc[2] - out_cyc[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen;
    out_ready = 1'b1;
    send(0, PT_C, {KEY_A, 128'h0}, 128'hbad0bad0bad0bad0bad0bad0bad0bad0);
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (bz[0] !== 1'b1) begin miscompares++; $display("FAIL rm_busy_before got %b expected 1", bz[0]); end
    rstn = 1'b0;
    #1;
    vectors++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
      miscompares++; $display("FAIL rm_async got valid=%b busy=%b expected 0 0", ov[0], bz[0]);
    end
    vectors++; if (ct[0] !== 128'h0 || ir[0] !== 1'b1) begin
      miscompares++; $display("FAIL rm_async_ct got ct=%h ready=%b expected 0 1", ct[0], ir[0]);
    end
    #20;
    rstn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov[0] || bz[0]) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rm_no_pulse got 1 expected 0"); end
    send(0, PT_C, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_out(0, n);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL rm_latency got %0d expected 10", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_perturb;
    int n;
    out_ready = 1'b1;
    send(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, {KEY_A, 128'h0}, 128'hf5d3d58503b9699de785895a96fdbaaf);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (ov[0]) begin n = c; break; end
    end
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL pert_latency got %0d expected 10", n); end
    vectors++; if (ct[0] !== 128'hf5d3d58503b9699de785895a96fdbaaf) begin
      miscompares++; $display("FAIL pert_ct got %h expected f5d3d58503b9699de785895a96fdbaaf", ct[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fips();
    test_key_sizes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_perturb();
    repeat (3) @(posedge clk);
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL sb_leftover got %0d expected 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
